// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback and drives all datapath selects, strobes and alu_op.
// Latency: outputs are combinational from the state register (FETCH ir_write/pc_write also follow i_mem_ready); illegal_op/mem_timeout are one-cycle registered pulses.
// Backpressure: FETCH, MEMRD and MEMWR hold until i_mem_ready; a watchdog aborts to FETCH after TIMEOUT_CYCLES wait cycles (0 disables it).
//
// Ports: i_clk, i_rst_n (async active-low), i_opcode (IR[31:26], sampled in DECODE), i_mem_ready;
//        strobes o_pc_write/o_branch/o_ir_write/o_mem_read/o_mem_write/o_reg_write (forced 0 in reset);
//        selects o_iord/o_mem_to_reg/o_reg_dst/o_alu_src_a/o_alu_src_b/o_pc_source; o_alu_op;
//        pulses o_illegal_op/o_mem_timeout; o_state for debug.
// Optional feature: define MIPS_MC_JUMP_EN to build the JUMP state; otherwise opcode 000010 is illegal.
module mips_mc_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_branch,
    output logic       o_ir_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_iord,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_source,
    output logic [1:0] o_alu_op,
    output logic       o_illegal_op,
    output logic       o_mem_timeout,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_MC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    // Abort fires on the cycle whose wait would make the count reach TIMEOUT_CYCLES.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam bit         WD_EN   = (TIMEOUT_CYCLES != 0);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_is_sw;
    logic       r_illegal;
    logic       r_timeout;

    state_t     w_next;
    logic       w_wait;
    logic       w_abort;
    logic       w_illegal;
    logic       w_pcw, w_br, w_irw, w_mr, w_mw, w_rw;
    logic       w_iord, w_m2r, w_rdst, w_asa;
    logic [1:0] w_asb, w_psrc, w_aop;

    always_comb begin
        w_next    = r_state;
        w_wait    = 1'b0;
        w_illegal = 1'b0;
        w_pcw     = 1'b0;
        w_br      = 1'b0;
        w_irw     = 1'b0;
        w_mr      = 1'b0;
        w_mw      = 1'b0;
        w_rw      = 1'b0;
        w_iord    = 1'b0;
        w_m2r     = 1'b0;
        w_rdst    = 1'b0;
        w_asa     = 1'b0;
        w_asb     = 2'b00;
        w_psrc    = 2'b00;
        w_aop     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mr   = 1'b1;
                w_asb  = 2'b01;
                w_irw  = i_mem_ready;
                w_pcw  = i_mem_ready;
                w_wait = 1'b1;
                if (i_mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_asb = 2'b11;
                case (i_opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
`ifdef MIPS_MC_JUMP_EN
                    OP_J:         w_next = S_JUMP;
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_asa  = 1'b1;
                w_asb  = 2'b10;
                w_next = r_is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                w_mr   = 1'b1;
                w_wait = 1'b1;
                if (i_mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_m2r  = 1'b1;
                w_rw   = 1'b1;
                w_next = S_FETCH;
            end
            S_MEMWR: begin
                w_iord = 1'b1;
                w_mw   = 1'b1;
                w_wait = 1'b1;
                if (i_mem_ready) w_next = S_FETCH;
            end
            S_EXEC: begin
                w_asa  = 1'b1;
                w_aop  = 2'b10;
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_rdst = 1'b1;
                w_rw   = 1'b1;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                w_asa  = 1'b1;
                w_aop  = 2'b01;
                w_psrc = 2'b01;
                w_br   = 1'b1;
                w_next = S_FETCH;
            end
            S_ADDIEX: begin
                w_asa  = 1'b1;
                w_asb  = 2'b10;
                w_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_rw   = 1'b1;
                w_next = S_FETCH;
            end
`ifdef MIPS_MC_JUMP_EN
            S_JUMP: begin
                w_psrc = 2'b10;
                w_pcw  = 1'b1;
                w_next = S_FETCH;
            end
`endif
            default: w_next = S_FETCH;
        endcase

        // Ready on the limit cycle wins because the abort requires !i_mem_ready.
        w_abort = WD_EN && w_wait && !i_mem_ready && (r_cnt == WD_LAST);
        if (w_abort) w_next = S_FETCH;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_cnt     <= 8'd0;
            r_is_sw   <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal;
            r_timeout <= w_abort;
            if (r_state == S_DECODE) r_is_sw <= (i_opcode == OP_SW);
            // Any state change (or a FETCH self-abort) is an entry: restart the wait count.
            if (w_abort || (w_next != r_state))
                r_cnt <= 8'd0;
            else if (w_wait && !i_mem_ready && (r_cnt != 8'hFF))
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // Strobes are squashed while reset is held; selects already show FETCH values then.
    assign o_pc_write    = w_pcw & i_rst_n;
    assign o_branch      = w_br  & i_rst_n;
    assign o_ir_write    = w_irw & i_rst_n;
    assign o_mem_read    = w_mr  & i_rst_n;
    assign o_mem_write   = w_mw  & i_rst_n;
    assign o_reg_write   = w_rw  & i_rst_n;
    assign o_iord        = w_iord;
    assign o_mem_to_reg  = w_m2r;
    assign o_reg_dst     = w_rdst;
    assign o_alu_src_a   = w_asa;
    assign o_alu_src_b   = w_asb;
    assign o_pc_source   = w_psrc;
    assign o_alu_op      = w_aop;
    assign o_illegal_op  = r_illegal;
    assign o_mem_timeout = r_timeout;
    assign o_state       = r_state;

endmodule
